// File: rtl/led_frame_pkg.sv
// Shared constants and state encoding for the APA102 frame scheduler.
package led_frame_pkg;

    localparam logic [31:0] START_WORD = 32'h0000_0000;
    localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;
    localparam logic [2:0]  LED_HDR    = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        START,
        FETCH,
        PIXEL,
        END,
        DONE
    } sched_state_t;

    function automatic logic [31:0] led_word(input logic [28:0] pix);
        return {LED_HDR, pix};
    endfunction

endpackage

// File: rtl/led_frame_scheduler_if.sv
// Strand request, pixel fetch and strand pin bundle of the frame scheduler.
interface led_frame_scheduler_if #(
    parameter int NSTRAND = 6,
    parameter int LEDW    = 4
);
    localparam int SW = (NSTRAND > 1) ? $clog2(NSTRAND) : 1;

    logic [NSTRAND-1:0]      frame_req;
    logic [NSTRAND*LEDW-1:0] led_cnt;
    logic                    pix_req;
    logic [SW-1:0]           pix_strand;
    logic [LEDW-1:0]         pix_index;
    logic                    pix_valid;
    logic [28:0]             pix_data;
    logic                    sck;
    logic [NSTRAND-1:0]      mosi;
    logic                    busy;
    logic                    frame_done;
    logic [SW-1:0]           done_strand;

    modport master (
        input  frame_req, led_cnt, pix_valid, pix_data,
        output pix_req, pix_strand, pix_index, sck, mosi, busy, frame_done, done_strand
    );

    modport slave (
        output frame_req, led_cnt, pix_valid, pix_data,
        input  pix_req, pix_strand, pix_index, sck, mosi, busy, frame_done, done_strand
    );
endinterface

// File: rtl/apa102_word_shifter.sv
// Serializes one 32-bit word MSB first: CLKDIV cycles sck low, CLKDIV cycles high, per bit.
module apa102_word_shifter #(
    parameter int CLKDIV = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [31:0] i_word,
    output logic        o_sck,
    output logic        o_bit,
    output logic        o_word_done
);
    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic          r_active;
    logic          r_sck;
    logic [DW-1:0] r_div;
    logic [4:0]    r_bit;
    logic [31:0]   r_sh;
    logic          w_div_end;

    assign w_div_end   = (r_div == DW'(CLKDIV - 1));
    // Combinational so the next word can be loaded with no idle gap on the strand
    assign o_word_done = r_active && r_sck && w_div_end && (r_bit == 5'd0);
    assign o_sck       = r_sck;
    assign o_bit       = r_active && r_sh[31];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_sck    <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
        end else if (i_load) begin
            r_active <= 1'b1;
            r_sck    <= 1'b0;
            r_div    <= '0;
            r_bit    <= 5'd31;
        end else if (r_active) begin
            if (w_div_end) begin
                r_div <= '0;
                r_sck <= ~r_sck;
                if (r_sck) begin
                    if (r_bit == 5'd0) r_active <= 1'b0;
                    else               r_bit    <= r_bit - 1'b1;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_load)                          r_sh <= i_word;
        else if (r_active && r_sck && w_div_end) r_sh <= {r_sh[30:0], 1'b0};
    end
endmodule

// File: rtl/led_frame_scheduler.sv
// Round-robin arbiter sharing one APA102 serializer among NSTRAND strands,
// fetching pixels on demand between the start and end words.
module led_frame_scheduler
    import led_frame_pkg::*;
#(
    parameter int NSTRAND = 6,
    parameter int LEDW    = 4,
    parameter int CLKDIV  = 64
) (
    input logic clk,
    input logic reset,
    led_frame_scheduler_if.master bus
);
    localparam int SW = (NSTRAND > 1) ? $clog2(NSTRAND) : 1;

    sched_state_t       r_state, w_next;
    logic [NSTRAND-1:0] r_pending, w_clr, w_mosi;
    logic [SW-1:0]      r_rr_ptr, r_grant, w_grant;
    logic [LEDW-1:0]    r_cnt, r_idx, w_idx_next, w_cnt_sel;
    logic               w_last, w_load, w_word_done, w_bit, w_sck;
    logic [31:0]        w_load_word;
    logic               w_pix_req, w_busy, w_frame_done;
    logic [SW-1:0]      w_done_strand;

    // First pending strand at or after ptr, wrapping modulo NSTRAND
    function automatic logic [SW-1:0] rr_pick(input logic [NSTRAND-1:0] pend,
                                              input logic [SW-1:0] ptr);
        logic [SW-1:0] pick;
        int            idx;
        pick = ptr;
        for (int k = NSTRAND - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NSTRAND;
            if (pend[idx]) pick = SW'(idx);
        end
        return pick;
    endfunction

    assign w_grant    = rr_pick(r_pending, r_rr_ptr);
    assign w_idx_next = r_idx + 1'b1;
    assign w_last     = (w_idx_next == r_cnt);

    always_comb begin
        w_cnt_sel = '0;
        for (int i = 0; i < NSTRAND; i++) begin
            w_clr[i]  = (r_state == ARB) && (w_grant == SW'(i));
            w_mosi[i] = w_bit && (r_grant == SW'(i));
            if (w_grant == SW'(i)) w_cnt_sel = bus.led_cnt[i*LEDW +: LEDW];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
        end else begin
            // A request arriving in the grant cycle re-queues the strand
            r_pending <= (r_pending & ~w_clr) | bus.frame_req;
            if (r_state == ARB) begin
                r_grant  <= w_grant;
                r_rr_ptr <= (w_grant == SW'(NSTRAND - 1)) ? '0 : w_grant + 1'b1;
                r_cnt    <= w_cnt_sel;
                r_idx    <= '0;
            end else if (r_state == PIXEL && w_word_done && !w_last) begin
                r_idx <= w_idx_next;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|r_pending) w_next = ARB;
            ARB:     w_next = START;
            START:   if (w_word_done) w_next = (r_cnt == '0) ? END : FETCH;
            FETCH:   if (bus.pix_valid) w_next = PIXEL;
            PIXEL:   if (w_word_done) w_next = w_last ? END : FETCH;
            END:     if (w_word_done) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_load        = 1'b0;
        w_load_word   = START_WORD;
        w_pix_req     = (r_state == FETCH);
        w_busy        = (r_state != IDLE) && (r_state != DONE);
        w_frame_done  = (r_state == DONE);
        w_done_strand = (r_state == DONE) ? r_grant : '0;
        case (r_state)
            ARB: w_load = 1'b1;
            START: if (w_word_done && r_cnt == '0) begin
                w_load      = 1'b1;
                w_load_word = END_WORD;
            end
            FETCH: if (bus.pix_valid) begin
                w_load      = 1'b1;
                w_load_word = led_word(bus.pix_data);
            end
            PIXEL: if (w_word_done && w_last) begin
                w_load      = 1'b1;
                w_load_word = END_WORD;
            end
            default: ;
        endcase
    end

    apa102_word_shifter #(.CLKDIV(CLKDIV)) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_word      (w_load_word),
        .o_sck       (w_sck),
        .o_bit       (w_bit),
        .o_word_done (w_word_done)
    );

    assign bus.pix_req     = w_pix_req;
    assign bus.pix_strand  = r_grant;
    assign bus.pix_index   = r_idx;
    assign bus.sck         = w_sck;
    assign bus.mosi        = w_mosi;
    assign bus.busy        = w_busy;
    assign bus.frame_done  = w_frame_done;
    assign bus.done_strand = w_done_strand;
endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed and randomized frames against a word-level model of the APA102 frame format.
module tb_led_frame_scheduler;
    localparam int NSTRAND = 6;
    localparam int LEDW    = 4;
    localparam int CLKDIV  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    led_frame_scheduler_if #(.NSTRAND(NSTRAND), .LEDW(LEDW)) bus ();

    led_frame_scheduler #(.NSTRAND(NSTRAND), .LEDW(LEDW), .CLKDIV(CLKDIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [28:0]        pix_mem [NSTRAND][16];
    int                 stall_cycles = 0;
    logic [NSTRAND-1:0] q_mosi [$];
    int                 rd_idx = 0;
    int                 sck_rises = 0;
    int                 pixreq_cycles = 0;
    int                 stall_viol = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bit sampler on sck rising edges plus fetch-handshake stability watch
    initial begin
        logic            prev_sck = 1'b0;
        logic            prev_req = 1'b0;
        logic [2:0]      prev_ps  = '0;
        logic [LEDW-1:0] prev_pi  = '0;
        forever begin
            @(negedge clk);
            if (bus.sck === 1'b1 && prev_sck === 1'b0) begin
                q_mosi.push_back(bus.mosi);
                sck_rises++;
            end
            if (bus.pix_req === 1'b1) begin
                pixreq_cycles++;
                if (bus.sck !== 1'b0) stall_viol++;
                if (prev_req && (bus.pix_strand !== prev_ps || bus.pix_index !== prev_pi))
                    stall_viol++;
            end
            prev_sck = bus.sck;
            prev_req = bus.pix_req;
            prev_ps  = bus.pix_strand;
            prev_pi  = bus.pix_index;
        end
    end

    // Pixel source: answers after stall_cycles FETCH cycles, junk data otherwise
    initial begin
        int wait_cnt = 0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.pix_req === 1'b1) begin
                if (wait_cnt >= stall_cycles && int'(bus.pix_strand) < NSTRAND) begin
                    bus.pix_valid = 1'b1;
                    bus.pix_data  = pix_mem[int'(bus.pix_strand)][int'(bus.pix_index)];
                end else begin
                    bus.pix_valid = 1'b0;
                    bus.pix_data  = 29'($urandom);
                    wait_cnt++;
                end
            end else begin
                bus.pix_valid = 1'b0;
                bus.pix_data  = 29'($urandom);
                wait_cnt      = 0;
            end
        end
    end

    function automatic logic [31:0] exp_word(input int s, input int cnt, input int w);
        if (w == 0)       return 32'h0000_0000;
        if (w == cnt + 1) return 32'hFFFF_FFFF;
        return {3'b111, pix_mem[s][w-1]};
    endfunction

    task automatic check_frame(input int s, input int cnt, input string tag);
        int nbits = (cnt + 2) * 32;
        int avail = q_mosi.size() - rd_idx;
        int other = 0;
        logic [31:0] word;
        chk({tag, "_nbits"}, 64'(avail), 64'(nbits));
        if (avail < nbits) begin
            rd_idx = q_mosi.size();
            return;
        end
        for (int w = 0; w < cnt + 2; w++) begin
            word = '0;
            for (int b = 0; b < 32; b++) begin
                word = {word[30:0], q_mosi[rd_idx][s]};
                for (int j = 0; j < NSTRAND; j++)
                    if (j != s && q_mosi[rd_idx][j] !== 1'b0) other++;
                rd_idx++;
            end
            chk($sformatf("%s_word%0d", tag, w), 64'(word), 64'(exp_word(s, cnt, w)));
        end
        chk({tag, "_other_mosi"}, 64'(other), 64'd0);
    endtask

    task automatic wait_done(output int s);
        s = -1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) begin
                s = int'(bus.done_strand);
                break;
            end
        end
    endtask

    task automatic wait_pixreq(input logic lvl, input string tag);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.pix_req === lvl) break;
        end
        chk(tag, 64'(bus.pix_req), 64'(lvl));
    endtask

    task automatic set_strand(input int s, input int cnt);
        bus.led_cnt[s*LEDW +: LEDW] = LEDW'(cnt);
        for (int i = 0; i < 16; i++) pix_mem[s][i] = 29'($urandom);
    endtask

    task automatic pulse_req(input logic [NSTRAND-1:0] m);
        @(negedge clk);
        bus.frame_req = m;
        @(negedge clk);
        bus.frame_req = '0;
    endtask

    task automatic do_frame(input int s, input int cnt, input int stall, input string tag);
        int g;
        stall_cycles = stall;
        pulse_req(NSTRAND'(1) << s);
        wait_done(g);
        chk({tag, "_strand"}, 64'(g), 64'(s));
        check_frame(s, cnt, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd_idx = q_mosi.size();
    endtask

    initial begin
        int g, base, pbase, vbase, cnt;
        int order0[3] = '{0, 2, 5};
        int order1[2] = '{0, 2};

        reset         = 1'b1;
        bus.frame_req = '0;
        bus.led_cnt   = '0;
        for (int s = 0; s < NSTRAND; s++) set_strand(s, 0);
        repeat (3) @(negedge clk);
        chk("rst_sck", 64'(bus.sck), 64'd0);
        chk("rst_mosi", 64'(bus.mosi), 64'd0);
        chk("rst_pix_req", 64'(bus.pix_req), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_frame_done", 64'(bus.frame_done), 64'd0);
        chk("rst_done_strand", 64'(bus.done_strand), 64'd0);
        reset = 1'b0;

        // Test 1: two-LED frame on strand 0 with same-cycle pixel responses
        bus.led_cnt[0 +: LEDW] = 4'd2;
        pix_mem[0][0] = 29'h1F_0000FF;
        pix_mem[0][1] = 29'h01_FF0000;
        stall_cycles  = 0;
        pbase = pixreq_cycles;
        @(negedge clk);
        bus.frame_req = 6'b000001;
        @(negedge clk);
        bus.frame_req = '0;
        chk("t1_busy_t1", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("t1_busy_t2", 64'(bus.busy), 64'd1);
        wait_done(g);
        chk("t1_strand", 64'(g), 64'd0);
        check_frame(0, 2, "t1");
        chk("t1_pixreq_cycles", 64'(pixreq_cycles - pbase), 64'd2);
        @(negedge clk);
        chk("t1_busy_after", 64'(bus.busy), 64'd0);

        // Test 3: zero-length frame on strand 3
        bus.led_cnt[3*LEDW +: LEDW] = 4'd0;
        pbase = pixreq_cycles;
        do_frame(3, 0, 0, "t3");
        chk("t3_no_pixreq", 64'(pixreq_cycles - pbase), 64'd0);

        // Test 4: same frame as test 1 with a 10-cycle fetch stall
        pbase = pixreq_cycles;
        vbase = stall_viol;
        do_frame(0, 2, 10, "t4");
        chk("t4_stall_stable", 64'(stall_viol - vbase), 64'd0);
        chk("t4_pixreq_cycles", 64'(pixreq_cycles - pbase), 64'd22);

        // Test 2: round-robin from a fresh pointer
        do_reset();
        stall_cycles = 0;
        set_strand(0, $urandom_range(0, 3));
        set_strand(2, $urandom_range(0, 3));
        set_strand(5, $urandom_range(0, 3));
        pulse_req(6'b100101);
        for (int k = 0; k < 3; k++) begin
            wait_done(g);
            chk($sformatf("t2_grant%0d", k), 64'(g), 64'(order0[k]));
            cnt = int'(bus.led_cnt[order0[k]*LEDW +: LEDW]);
            check_frame(order0[k], cnt, $sformatf("t2_f%0d", k));
        end
        pulse_req(6'b000101);
        for (int k = 0; k < 2; k++) begin
            wait_done(g);
            chk($sformatf("t2_wrap_grant%0d", k), 64'(g), 64'(order1[k]));
            cnt = int'(bus.led_cnt[order1[k]*LEDW +: LEDW]);
            check_frame(order1[k], cnt, $sformatf("t2_w%0d", k));
        end

        // Test 5: strand 1 re-requests while its own pixel is shifting
        set_strand(1, 2);
        stall_cycles = 0;
        pulse_req(6'b000010);
        wait_pixreq(1'b1, "t5_fetch");
        wait_pixreq(1'b0, "t5_pixel");
        pulse_req(6'b000010);
        wait_done(g);
        chk("t5_first_strand", 64'(g), 64'd1);
        check_frame(1, 2, "t5a");
        wait_done(g);
        chk("t5_second_strand", 64'(g), 64'd1);
        check_frame(1, 2, "t5b");

        // Test 6: reset while strand 4 is in PIXEL with strand 2 pending
        set_strand(4, 3);
        set_strand(2, $urandom_range(1, 4));
        pulse_req(6'b010000);
        wait_pixreq(1'b1, "t6_fetch");
        wait_pixreq(1'b0, "t6_pixel");
        pulse_req(6'b000100);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_rst_sck", 64'(bus.sck), 64'd0);
        chk("t6_rst_mosi", 64'(bus.mosi), 64'd0);
        chk("t6_rst_busy", 64'(bus.busy), 64'd0);
        chk("t6_rst_pix_req", 64'(bus.pix_req), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        base = sck_rises;
        repeat (30) @(negedge clk);
        chk("t6_pending_cleared_busy", 64'(bus.busy), 64'd0);
        chk("t6_pending_cleared_sck", 64'(sck_rises - base), 64'd0);
        rd_idx = q_mosi.size();
        cnt = int'(bus.led_cnt[2*LEDW +: LEDW]);
        do_frame(2, cnt, 0, "t6b");

        // Randomized single-strand frames with random lengths and stalls
        for (int r = 0; r < 4; r++) begin
            int s = $urandom_range(0, NSTRAND - 1);
            int c = $urandom_range(0, 5);
            set_strand(s, c);
            do_frame(s, c, $urandom_range(0, 4), $sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
